alu_shift_mem_unit: RTL and testbench

//   Execute/memory datapath slice of the 8-bit pipelined CPU.

---
 rtl/alu_shift_mem_unit_if.sv | 49 ++++
 rtl/alu_shift_mem_unit.sv | 123 ++++++++++++
 tb/tb_alu_shift_mem_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_shift_mem_unit_if.sv
// rtl/alu_shift_mem_unit_if.sv - bundle of ALU, shifter and data-memory signals for the execute/memory slice
interface alu_shift_mem_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  // ALU
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_cin;
  logic [DATA_W-1:0] alu_out;
  logic              alu_co;
  logic              alu_z;

  // Barrel shifter / rotator
  logic [DATA_W-1:0] sh_data;
  logic [2:0]        sh_count;
  logic              sh_dir;
  logic              sh_ro_bar;
  logic [DATA_W-1:0] sh_out;
  logic              sh_c;
  logic              sh_z;

  // Data memory
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Pipeline side that drives operands and consumes results
  modport master (
    output alu_op, alu_a, alu_b, alu_cin,
    input  alu_out, alu_co, alu_z,
    output sh_data, sh_count, sh_dir, sh_ro_bar,
    input  sh_out, sh_c, sh_z,
    output mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Datapath slice itself
  modport slave (
    input  alu_op, alu_a, alu_b, alu_cin,
    output alu_out, alu_co, alu_z,
    input  sh_data, sh_count, sh_dir, sh_ro_bar,
    output sh_out, sh_c, sh_z,
    input  mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/alu_shift_mem_unit.sv
// rtl/alu_shift_mem_unit.sv - 8-bit execute/memory slice: ALU, barrel shifter/rotator, 256x8 data memory
module alu_shift_mem_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_shift_mem_unit_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MASK = 3'b101;
  localparam logic [2:0] OP_PASB = 3'b110;
  localparam logic [2:0] OP_PASA = 3'b111;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   alu_sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  // Arithmetic uses one extra bit so the top bit is carry (ADD) or borrow (SUB)
  always_comb begin
    alu_sum   = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        alu_sum   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{DATA_W{1'b0}}, bus.alu_cin};
        alu_res   = alu_sum[DATA_W-1:0];
        alu_carry = alu_sum[DATA_W];
      end
      OP_SUB: begin
        alu_sum   = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {{DATA_W{1'b0}}, bus.alu_cin};
        alu_res   = alu_sum[DATA_W-1:0];
        alu_carry = alu_sum[DATA_W];
      end
      OP_AND:  alu_res = bus.alu_a & bus.alu_b;
      OP_OR:   alu_res = bus.alu_a | bus.alu_b;
      OP_XOR:  alu_res = bus.alu_a ^ bus.alu_b;
      OP_MASK: alu_res = bus.alu_a & ~bus.alu_b;
      OP_PASB: alu_res = bus.alu_b;
      OP_PASA: alu_res = bus.alu_a;
      default: alu_res = '0;
    endcase
  end

  assign bus.alu_out = alu_res;
  assign bus.alu_co  = alu_carry;
  assign bus.alu_z   = (alu_res == '0);

  // ---------------------------------------------------------------------------
  // Barrel shifter / rotator
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]     sh_ext_l;   // {carry, result} for logical left
  logic [DATA_W:0]     sh_ext_r;   // {result, carry} for logical right
  logic [2*DATA_W-1:0] sh_dbl;
  logic [2*DATA_W-1:0] sh_rot_l;
  logic [2*DATA_W-1:0] sh_rot_r;
  logic [DATA_W-1:0]   sh_res;
  logic                sh_carry;

  // Extra guard bit catches the last bit shifted out; doubled word gives rotations
  always_comb begin
    sh_ext_l = {1'b0, bus.sh_data} << bus.sh_count;
    sh_ext_r = {bus.sh_data, 1'b0} >> bus.sh_count;
    sh_dbl   = {bus.sh_data, bus.sh_data};
    sh_rot_l = sh_dbl << bus.sh_count;
    sh_rot_r = sh_dbl >> bus.sh_count;
    sh_res   = bus.sh_data;
    sh_carry = 1'b0;
    if (bus.sh_count != 3'd0) begin
      if (bus.sh_ro_bar) begin
        if (bus.sh_dir) begin
          sh_res   = sh_ext_r[DATA_W:1];
          sh_carry = sh_ext_r[0];
        end else begin
          sh_res   = sh_ext_l[DATA_W-1:0];
          sh_carry = sh_ext_l[DATA_W];
        end
      end else begin
        if (bus.sh_dir) begin
          sh_res   = sh_rot_r[DATA_W-1:0];
          sh_carry = sh_rot_r[DATA_W-1];
        end else begin
          sh_res   = sh_rot_l[2*DATA_W-1:DATA_W];
          sh_carry = sh_rot_l[DATA_W];
        end
      end
    end
  end

  assign bus.sh_out = sh_res;
  assign bus.sh_c   = sh_carry;
  assign bus.sh_z   = (sh_res == '0);

  // ---------------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Reset wipes every word at once; otherwise a single-port synchronous write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.mem_write) begin
      mem_q[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Asynchronous read so a write is visible right after its clock edge
  assign bus.mem_rdata = mem_q[bus.mem_addr];

endmodule

// File: tb/tb_alu_shift_mem_unit.sv
// tb/tb_alu_shift_mem_unit.sv - self-checking bench for alu_shift_mem_unit
module tb_alu_shift_mem_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [7:0] ref_mem [256];

  alu_shift_mem_unit_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  alu_shift_mem_unit #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {z, co, out}
  function automatic logic [9:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
    int   r;
    logic co;
    co = 1'b0;
    case (op)
      3'd0: begin r = int'(a) + int'(b) + int'(cin); co = (r > 255); end
      3'd1: begin r = int'(a) - int'(b) - int'(cin); co = (r < 0); if (r < 0) r = r + 256; end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = int'(a & ~b);
      3'd6: r = int'(b);
      default: r = int'(a);
    endcase
    r = r % 256;
    return {(r == 0), co, r[7:0]};
  endfunction

  // Moves one bit at a time; carry is the last bit that left (or wrapped). Returns {z, c, out}
  function automatic logic [9:0] sh_model(input logic [7:0] d, input int n,
                                          input logic dir, input logic logical);
    logic [7:0] v;
    logic       c;
    v = d;
    c = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!dir) begin
        c = v[7];
        v = {v[6:0], (logical ? 1'b0 : c)};
      end else begin
        c = v[0];
        v = {(logical ? 1'b0 : c), v[7:1]};
      end
    end
    return {(v == 8'h00), c, v};
  endfunction

  task automatic mem_write_cycle(input logic [7:0] addr, input logic [7:0] data, input logic we);
    @(negedge clk);
    bus.mem_write = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    @(posedge clk);
    if (we && !rst) ref_mem[addr] = data;
    #1;
    bus.mem_write = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] a;
    for (int i = 0; i < 16; i++) begin
      a = (i == 15) ? 8'hFF : 8'($urandom_range(0, 255));
      bus.mem_addr = a;
      #1;
      n_cmp++;
      if (bus.mem_rdata !== 8'h00) begin
        n_err++;
        $display("FAIL reset_rdata addr=%h got %h want 00", a, bus.mem_rdata);
      end
    end
  endtask

  task automatic test_alu;
    logic [2:0]  t_op  [7] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd7, 3'd5};
    logic [7:0]  t_a   [7] = '{8'hFF, 8'h7F, 8'h05, 8'h07, 8'hF0, 8'h00, 8'hFF};
    logic [7:0]  t_b   [7] = '{8'h01, 8'h01, 8'h07, 8'h07, 8'h0F, 8'h55, 8'h0F};
    logic        t_ci  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0]  t_exp [7] = '{{1'b1, 1'b1, 8'h00}, {1'b0, 1'b0, 8'h81}, {1'b0, 1'b1, 8'hFE},
                               {1'b1, 1'b0, 8'h00}, {1'b1, 1'b0, 8'h00}, {1'b1, 1'b0, 8'h00},
                               {1'b0, 1'b0, 8'hF0}};
    logic [9:0]  exp;
    logic [9:0]  got;
    for (int i = 0; i < 7 + 300; i++) begin
      if (i < 7) begin
        bus.alu_op = t_op[i]; bus.alu_a = t_a[i]; bus.alu_b = t_b[i]; bus.alu_cin = t_ci[i];
        exp = t_exp[i];
      end else begin
        bus.alu_op  = 3'($urandom_range(0, 7));
        bus.alu_a   = (i % 9 == 0) ? bus.alu_b : 8'($urandom_range(0, 255));
        bus.alu_b   = 8'($urandom_range(0, 255));
        bus.alu_cin = 1'($urandom_range(0, 1));
        exp = alu_model(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);
      end
      #1;
      got = {bus.alu_z, bus.alu_co, bus.alu_out};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL alu op=%0d a=%h b=%h cin=%b got z/co/out=%b/%b/%h want %b/%b/%h",
                 bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin,
                 got[9], got[8], got[7:0], exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_shifter;
    logic [7:0] t_d   [7] = '{8'h81, 8'h81, 8'h81, 8'h01, 8'h80, 8'h00, 8'h00};
    logic [2:0] t_n   [7] = '{3'd1, 3'd7, 3'd0, 3'd1, 3'd3, 3'd5, 3'd2};
    logic       t_dir [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       t_log [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [9:0] t_exp [7] = '{{1'b0, 1'b1, 8'h02}, {1'b0, 1'b0, 8'h01}, {1'b0, 1'b0, 8'h81},
                              {1'b0, 1'b1, 8'h80}, {1'b0, 1'b0, 8'h04}, {1'b1, 1'b0, 8'h00},
                              {1'b1, 1'b0, 8'h00}};
    logic [9:0] exp;
    logic [9:0] got;
    for (int i = 0; i < 7 + 400; i++) begin
      if (i < 7) begin
        bus.sh_data = t_d[i]; bus.sh_count = t_n[i]; bus.sh_dir = t_dir[i]; bus.sh_ro_bar = t_log[i];
        exp = t_exp[i];
      end else begin
        bus.sh_data   = 8'($urandom_range(0, 255));
        bus.sh_count  = 3'($urandom_range(0, 7));
        bus.sh_dir    = 1'($urandom_range(0, 1));
        bus.sh_ro_bar = 1'($urandom_range(0, 1));
        exp = sh_model(bus.sh_data, int'(bus.sh_count), bus.sh_dir, bus.sh_ro_bar);
      end
      #1;
      got = {bus.sh_z, bus.sh_c, bus.sh_out};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL shifter d=%h n=%0d dir=%b log=%b got z/c/out=%b/%b/%h want %b/%b/%h",
                 bus.sh_data, bus.sh_count, bus.sh_dir, bus.sh_ro_bar,
                 got[9], got[8], got[7:0], exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_memory;
    logic [7:0] t_addr [3] = '{8'h10, 8'hFF, 8'h10};
    logic [7:0] t_exp  [3] = '{8'hA5, 8'h3C, 8'hA5};
    mem_write_cycle(8'h10, 8'hA5, 1'b1);
    mem_write_cycle(8'hFF, 8'h3C, 1'b1);
    mem_write_cycle(8'h10, 8'h99, 1'b0);   // edge without write enable
    for (int i = 0; i < 3; i++) begin
      bus.mem_addr = t_addr[i];
      #1;
      n_cmp++;
      if (bus.mem_rdata !== t_exp[i]) begin
        n_err++;
        $display("FAIL mem_directed addr=%h got %h want %h", t_addr[i], bus.mem_rdata, t_exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a;
    logic [7:0] d;
    logic       we;
    for (int i = 0; i < 200; i++) begin
      a  = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      we = ($urandom_range(0, 3) != 0);
      mem_write_cycle(a, d, we);
      // same-address readback right after the edge, then a random address
      for (int k = 0; k < 2; k++) begin
        if (k == 1) bus.mem_addr = 8'($urandom_range(0, 255));
        #1;
        n_cmp++;
        if (bus.mem_rdata !== ref_mem[bus.mem_addr]) begin
          n_err++;
          $display("FAIL mem_b2b addr=%h got %h want %h", bus.mem_addr, bus.mem_rdata, ref_mem[bus.mem_addr]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    mem_write_cycle(8'h10, 8'hA5, 1'b1);
    mem_write_cycle(8'h22, 8'h5A, 1'b1);
    @(negedge clk);
    #2;
    bus.mem_addr = 8'h10;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    #1;
    n_cmp++;
    if (bus.mem_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_async addr=10 got %h want 00", bus.mem_rdata);
    end
    mem_write_cycle(8'h10, 8'h77, 1'b1);   // ignored while reset held
    #1;
    n_cmp++;
    if (bus.mem_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_write_ignored addr=10 got %h want 00", bus.mem_rdata);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    bus.mem_addr = 8'h22;
    #1;
    n_cmp++;
    if (bus.mem_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_cleared addr=22 got %h want 00", bus.mem_rdata);
    end
    mem_write_cycle(8'h22, 8'hC3, 1'b1);
    #1;
    n_cmp++;
    if (bus.mem_rdata !== 8'hC3) begin
      n_err++;
      $display("FAIL post_reset_write addr=22 got %h want c3", bus.mem_rdata);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    bus.alu_op    = 3'd0;
    bus.alu_a     = 8'h00;
    bus.alu_b     = 8'h00;
    bus.alu_cin   = 1'b0;
    bus.sh_data   = 8'h00;
    bus.sh_count  = 3'd0;
    bus.sh_dir    = 1'b0;
    bus.sh_ro_bar = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = 8'h00;
    bus.mem_wdata = 8'h00;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_alu();
    test_shifter();
    test_memory();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
